// File: rtl/if_pc_ras_pkg.sv
// Shared definitions for the fetch-stage PC / return-address-stack block.
package if_pc_ras_pkg;

    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_INST_BYTES = 2;

    // Source selected for the next fetch address
    typedef enum logic [2:0] {
        SEQ,
        BR,
        RET,
        FLUSH,
        HOLD
    } next_src_e;

endpackage

// File: rtl/if_pc_ras_ras.sv
// Circular return-address stack: push, pop, swap-top and clear.
// When full, a push overwrites the oldest entry and the count saturates.
module if_ras #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              swap,
    input  logic              clear,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_top;
    logic              can_pop;

    // ptr names the next free slot; the top entry sits just below it
    assign ptr_top = ptr - PTR_W'(1);
    assign top     = mem[ptr_top];
    assign can_pop = pop && (cnt != '0);

    // Pointer and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (clear) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (cnt != CNT_W'(DEPTH))
                cnt <= cnt + CNT_W'(1);
        end else if (can_pop) begin
            ptr <= ptr_top;
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Entry storage; deliberately unreset, unreadable while cnt is zero
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push)
                mem[ptr] <= push_data;
            else if (swap)
                mem[ptr_top] <= push_data;
        end
    end

endmodule

// File: rtl/if_pc_ras.sv
// Fetch PC generator with return-address-stack prediction.
// Priority: flush, return (RAS non-empty), taken branch, sequential.
module if_pc_ras
    import if_pc_ras_pkg::*;
#(
    parameter int unsigned          ADDR_W     = DEF_ADDR_W,
    parameter int unsigned          INST_BYTES = DEF_INST_BYTES,
    parameter logic [ADDR_W-1:0]    RESET_VEC  = '0,
    parameter int unsigned          RAS_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_en,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            flush_addr,
    input  logic                         branch_taken,
    input  logic [ADDR_W-1:0]            branch_addr,
    input  logic                         is_call,
    input  logic                         is_ret,
    output logic [ADDR_W-1:0]            pc_addr,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
    output logic                         misalign
);

    localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LOW_BITS = ADDR_W'(INST_BYTES - 1);

    next_src_e         src;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] next_pc;
    logic              next_misalign;
    logic              ret_hit;
    logic              call;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_swap;
    logic [ADDR_W-1:0] ras_top;

    // Sequential address doubles as the return address; wraps silently
    assign seq_addr = pc_addr + ADDR_W'(INST_BYTES);
    assign ret_hit  = is_ret && (ras_cnt != '0);
    assign call     = branch_taken && is_call;

    // Next-PC source selection
    always_comb begin
        src = HOLD;
        if (flush)
            src = FLUSH;
        else if (pc_en) begin
            if (ret_hit)
                src = RET;
            else if (branch_taken)
                src = BR;
            else
                src = SEQ;
        end
    end

    // RAS control; call+ret with an empty stack degrades to a plain call
    always_comb begin
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        ras_swap = 1'b0;
        if (!flush && pc_en) begin
            ras_push = call && !ret_hit;
            ras_pop  = ret_hit && !call;
            ras_swap = ret_hit && call;
        end
    end

    // Target mux with alignment forcing and misalign detection
    always_comb begin
        raw_target    = '0;
        next_pc       = pc_addr;
        next_misalign = 1'b0;
        unique case (src)
            FLUSH:   raw_target = flush_addr;
            BR:      raw_target = branch_addr;
            RET:     raw_target = ras_top;
            default: raw_target = '0;
        endcase
        unique case (src)
            FLUSH, BR, RET: begin
                next_pc       = raw_target & ~LOW_BITS;
                next_misalign = |(raw_target & LOW_BITS);
            end
            SEQ:     next_pc = seq_addr;
            default: next_pc = pc_addr;
        endcase
    end

    // PC and misalign registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_addr  <= RESET_VEC;
            misalign <= 1'b0;
        end else begin
            pc_addr  <= next_pc;
            misalign <= next_misalign;
        end
    end

    if_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH),
        .CNT_W  (CNT_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .swap      (ras_swap),
        .clear     (flush),
        .push_data (seq_addr),
        .top       (ras_top),
        .cnt       (ras_cnt)
    );

endmodule

// File: tb/tb_if_pc_ras.sv
// Directed self-checking bench for if_pc_ras (default parameters).
module tb_if_pc_ras;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_en;
    logic        flush;
    logic [15:0] flush_addr;
    logic        branch_taken;
    logic [15:0] branch_addr;
    logic        is_call;
    logic        is_ret;
    logic [15:0] pc_addr;
    logic [2:0]  ras_cnt;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    if_pc_ras #(
        .ADDR_W     (16),
        .INST_BYTES (2),
        .RESET_VEC  (16'h0000),
        .RAS_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_en        (pc_en),
        .flush        (flush),
        .flush_addr   (flush_addr),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .is_call      (is_call),
        .is_ret       (is_ret),
        .pc_addr      (pc_addr),
        .ras_cnt      (ras_cnt),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_en        = 1'b0;
        flush        = 1'b0;
        flush_addr   = '0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        is_call      = 1'b0;
        is_ret       = 1'b0;
    endtask

    task automatic go_to(input logic [15:0] a);
        idle();
        flush = 1'b1;
        flush_addr = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (pc_addr !== 16'h0000 || ras_cnt !== 3'd0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h cnt=%0d mis=%b want pc=0000 cnt=0 mis=0", pc_addr, ras_cnt, misalign);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [15:0] exp;
        idle();
        checks++;
        if (pc_addr !== 16'h0000) begin
            errors++;
            $display("FAIL seq_start: pc=%h want 0000", pc_addr);
        end
        pc_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 16'(2 * i);
            checks++;
            if (pc_addr !== exp) begin
                errors++;
                $display("FAIL seq_%0d: pc=%h want %h", i, pc_addr, exp);
            end
        end
        idle();
    endtask

    task automatic test_call_ret();
        go_to(16'h0010);
        pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1; branch_addr = 16'h0100;
        tick();
        checks++;
        if (pc_addr !== 16'h0100 || ras_cnt !== 3'd1) begin
            errors++;
            $display("FAIL call: pc=%h cnt=%0d want pc=0100 cnt=1", pc_addr, ras_cnt);
        end
        idle();
        pc_en = 1'b1; is_ret = 1'b1;
        tick();
        checks++;
        if (pc_addr !== 16'h0012 || ras_cnt !== 3'd0) begin
            errors++;
            $display("FAIL ret: pc=%h cnt=%0d want pc=0012 cnt=0", pc_addr, ras_cnt);
        end
        idle();
    endtask

    task automatic test_nested();
        logic [15:0] exp_pc [5];
        logic [2:0]  exp_cnt [5];
        exp_pc  = '{16'h2000, 16'h2100, 16'h2200, 16'h2300, 16'h2400};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        go_to(16'h1000);
        for (int i = 0; i < 5; i++) begin
            pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1;
            branch_addr = 16'h2000 + 16'(i) * 16'h0100;
            tick();
            checks++;
            if (pc_addr !== exp_pc[i] || ras_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL nest_call_%0d: pc=%h cnt=%0d want pc=%h cnt=%0d", i, pc_addr, ras_cnt, exp_pc[i], exp_cnt[i]);
            end
        end
        // oldest return address 1002 was overwritten; fifth ret falls through sequentially
        exp_pc  = '{16'h2302, 16'h2202, 16'h2102, 16'h2002, 16'h2004};
        exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        idle();
        for (int i = 0; i < 5; i++) begin
            pc_en = 1'b1; is_ret = 1'b1;
            tick();
            checks++;
            if (pc_addr !== exp_pc[i] || ras_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL nest_ret_%0d: pc=%h cnt=%0d want pc=%h cnt=%0d", i, pc_addr, ras_cnt, exp_pc[i], exp_cnt[i]);
            end
        end
        // ret on empty stack with a predicted-taken target uses that target
        branch_taken = 1'b1; branch_addr = 16'h0800;
        tick();
        checks++;
        if (pc_addr !== 16'h0800 || ras_cnt !== 3'd0) begin
            errors++;
            $display("FAIL ret_empty_br: pc=%h cnt=%0d want pc=0800 cnt=0", pc_addr, ras_cnt);
        end
        idle();
    endtask

    task automatic test_flush();
        go_to(16'h0030);
        pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1; branch_addr = 16'h0040;
        tick();
        pc_en = 1'b0; flush = 1'b1; flush_addr = 16'h0200;
        branch_taken = 1'b1; is_call = 1'b1; branch_addr = 16'h0500;
        tick();
        checks++;
        if (pc_addr !== 16'h0200 || ras_cnt !== 3'd0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL flush: pc=%h cnt=%0d mis=%b want pc=0200 cnt=0 mis=0", pc_addr, ras_cnt, misalign);
        end
        idle();
        pc_en = 1'b1; is_ret = 1'b1;
        tick();
        checks++;
        if (pc_addr !== 16'h0202 || ras_cnt !== 3'd0) begin
            errors++;
            $display("FAIL flush_nopush: pc=%h cnt=%0d want pc=0202 cnt=0", pc_addr, ras_cnt);
        end
        idle();
    endtask

    task automatic test_misalign();
        go_to(16'h0050);
        pc_en = 1'b1; branch_taken = 1'b1; branch_addr = 16'h0101;
        tick();
        checks++;
        if (pc_addr !== 16'h0100 || misalign !== 1'b1) begin
            errors++;
            $display("FAIL misalign_hit: pc=%h mis=%b want pc=0100 mis=1", pc_addr, misalign);
        end
        idle();
        pc_en = 1'b1;
        tick();
        checks++;
        if (pc_addr !== 16'h0102 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: pc=%h mis=%b want pc=0102 mis=0", pc_addr, misalign);
        end
        idle();
    endtask

    task automatic test_hold();
        go_to(16'h0060);
        pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1; branch_addr = 16'h0070;
        tick();
        pc_en = 1'b0; is_ret = 1'b1; branch_addr = 16'h0090;
        tick();
        tick();
        checks++;
        if (pc_addr !== 16'h0070 || ras_cnt !== 3'd1) begin
            errors++;
            $display("FAIL hold: pc=%h cnt=%0d want pc=0070 cnt=1", pc_addr, ras_cnt);
        end
        idle();
    endtask

    task automatic test_swap();
        go_to(16'h0300);
        pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1; branch_addr = 16'h0400;
        tick();
        is_ret = 1'b1; branch_addr = 16'h0500;
        tick();
        checks++;
        if (pc_addr !== 16'h0302 || ras_cnt !== 3'd1) begin
            errors++;
            $display("FAIL swap: pc=%h cnt=%0d want pc=0302 cnt=1", pc_addr, ras_cnt);
        end
        idle();
        pc_en = 1'b1; is_ret = 1'b1;
        tick();
        checks++;
        if (pc_addr !== 16'h0402 || ras_cnt !== 3'd0) begin
            errors++;
            $display("FAIL swap_ret: pc=%h cnt=%0d want pc=0402 cnt=0", pc_addr, ras_cnt);
        end
        idle();
    endtask

    task automatic test_callret_empty();
        go_to(16'h0580);
        pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1; is_ret = 1'b1; branch_addr = 16'h0600;
        tick();
        checks++;
        if (pc_addr !== 16'h0600 || ras_cnt !== 3'd1) begin
            errors++;
            $display("FAIL callret_empty: pc=%h cnt=%0d want pc=0600 cnt=1", pc_addr, ras_cnt);
        end
        idle();
        pc_en = 1'b1; is_ret = 1'b1;
        tick();
        checks++;
        if (pc_addr !== 16'h0582 || ras_cnt !== 3'd0) begin
            errors++;
            $display("FAIL callret_empty_ret: pc=%h cnt=%0d want pc=0582 cnt=0", pc_addr, ras_cnt);
        end
        idle();
    endtask

    task automatic test_wrap();
        go_to(16'hFFFE);
        pc_en = 1'b1;
        tick();
        checks++;
        if (pc_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_seq: pc=%h want 0000", pc_addr);
        end
        go_to(16'hFFFE);
        pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1; branch_addr = 16'h0700;
        tick();
        idle();
        pc_en = 1'b1; is_ret = 1'b1;
        tick();
        checks++;
        if (pc_addr !== 16'h0000 || ras_cnt !== 3'd0) begin
            errors++;
            $display("FAIL wrap_ret: pc=%h cnt=%0d want pc=0000 cnt=0", pc_addr, ras_cnt);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        go_to(16'h0900);
        pc_en = 1'b1; branch_taken = 1'b1; is_call = 1'b1; branch_addr = 16'h0A00;
        tick();
        branch_addr = 16'h0B00;
        tick();
        checks++;
        if (ras_cnt !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_setup: cnt=%0d want 2", ras_cnt);
        end
        idle();
        pc_en = 1'b1; is_ret = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pc_addr !== 16'h0000 || ras_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_async: pc=%h cnt=%0d want pc=0000 cnt=0", pc_addr, ras_cnt);
        end
        tick();
        rst = 1'b1;
        idle();
        tick();
        checks++;
        if (pc_addr !== 16'h0000 || ras_cnt !== 3'd0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: pc=%h cnt=%0d mis=%b want pc=0000 cnt=0 mis=0", pc_addr, ras_cnt, misalign);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_sequential();
        test_call_ret();
        test_nested();
        test_flush();
        test_misalign();
        test_hold();
        test_swap();
        test_callret_empty();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_pc_ras.md
IF_PC_RAS -- requirements
Module: if_pc_ras

Interface
REQ-001 Parameter ADDR_W, default 16: width of every address.
REQ-002 Parameter INST_BYTES, default 2: sequential PC increment; power of two.
REQ-003 Parameter RESET_VEC, default 16'h0: PC value loaded by reset.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 pc_en  in  1  advance the PC this cycle; low means stall.
REQ-008 flush  in  1  redirect from execute (mispredict or exception); acts regardless of pc_en.
REQ-009 flush_addr  in  ADDR_W  redirect target.
REQ-010 branch_taken  in  1  predicted-taken branch or call at pc_addr.
REQ-011 branch_addr  in  ADDR_W  predicted target.
REQ-012 is_call  in  1  instruction at pc_addr is a call; qualified by branch_taken.
REQ-013 is_ret  in  1  instruction at pc_addr is a return.
REQ-014 pc_addr  out  ADDR_W  current fetch address.
REQ-015 ras_cnt  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-016 misalign  out  1  one-cycle pulse: the accepted target had nonzero bits below INST_BYTES.

Function
REQ-017 Next-PC priority: flush, then ret, then branch_taken, then pc_addr+INST_BYTES; pc_en=0 with flush=0 holds pc_addr and the RAS.
REQ-018 Ret with ras_cnt>0 pops; next PC is the top entry; ras_cnt decrements.
REQ-019 Ret with ras_cnt=0 uses branch_addr when branch_taken=1, otherwise the sequential PC; RAS unchanged.
REQ-020 Call (branch_taken=1, is_call=1, is_ret=0) pushes pc_addr+INST_BYTES; next PC is branch_addr.
REQ-021 Push when full overwrites the oldest entry (circular pointer wrap); ras_cnt saturates at RAS_DEPTH.
REQ-022 Call and ret together with ras_cnt>0: next PC is the top entry; the top is replaced by pc_addr+INST_BYTES; ras_cnt unchanged.
REQ-023 Call and ret together with ras_cnt=0: treated as a call (REQ-020).
REQ-024 Flush sets the next PC to flush_addr, sets ras_cnt to 0, and ignores branch_taken, is_call and is_ret in the same cycle.
REQ-025 Every accepted target (flush_addr, branch_addr, popped entry) has its bits below log2(INST_BYTES) forced to zero; misalign pulses in the following cycle if any forced bit was 1.
REQ-026 Sequential increment and return-address computation wrap modulo 2^ADDR_W with no flag.
REQ-027 Latency: a decision in cycle N is visible on pc_addr in cycle N+1.

Reset
REQ-028 While rst=0: pc_addr=RESET_VEC, ras_cnt=0, misalign=0, RAS pointer=0; asynchronous assertion, synchronous deassertion edge.
REQ-029 RAS entry storage is not reset; entries are unreadable while ras_cnt=0.
REQ-030 Reset mid-operation discards any pending push, pop or redirect.

Structure
REQ-031 The shared defines package holds the next-PC source enum (SEQ, BR, RET, FLUSH, HOLD) and the default ADDR_W/INST_BYTES constants.
REQ-032 The RAS is one sub-module, if_ras (push, pop, swap, clear, top, cnt); next-PC selection stays in if_pc_ras.

Verification
REQ-033 Reset release then pc_en=1 for 3 cycles -> pc_addr 0x0000, 0x0002, 0x0004, 0x0006.
REQ-034 At pc 0x0010, call to 0x0100; at 0x0100, ret -> pc 0x0100 then 0x0012; ras_cnt 0 to 1 to 0.
REQ-035 Five nested calls with RAS_DEPTH=4, then five rets -> first four rets return the newest four addresses; fifth ret falls through per REQ-019; ras_cnt saturates at 4.
REQ-036 flush=1 with flush_addr=0x0200, branch_taken=1, is_call=1, pc_en=0 -> pc 0x0200, ras_cnt 0, no push.
REQ-037 Branch to 0x0101 -> pc 0x0100, misalign=1 for exactly one cycle.
REQ-038 rst=0 asserted mid-ret with ras_cnt=2 -> pc_addr=RESET_VEC immediately, ras_cnt 0 immediately.
